// File: rtl/tdm_mux_8x1_pkg.sv
// Shared definitions for the TDM mux/demux family: channel sizing,
// FSM state encoding and the channel-to-bit index mapping.
package tdm_mux_8x1_pkg;

  localparam int CH_W  = 3;
  localparam int NCH   = 8;
  localparam int GAP_W = 4;

  localparam logic [CH_W-1:0] CNT_LAST = CH_W'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  // Word bit carried on a given channel. For MSB-first, 7-cnt is simply ~cnt
  // at a 3-bit channel width.
  function automatic logic [CH_W-1:0] chan_bit_idx(input logic [CH_W-1:0] cnt,
                                                   input logic            lsb_first);
    return lsb_first ? cnt : ~cnt;
  endfunction

endpackage

// File: rtl/tdm_mux_8x1_if.sv
// Parallel-load handshake plus serial/select/frame stream of the TDM mux.
interface tdm_mux_8x1_if;
  import tdm_mux_8x1_pkg::*;

  logic [NCH-1:0] d;
  logic           load;
  logic           ready;
  logic           y;
  logic           s0;
  logic           s1;
  logic           s2;
  logic           vld;
  logic           frame;

  modport master (
    output d, load,
    input  ready, y, s0, s1, s2, vld, frame
  );

  modport slave (
    input  d, load,
    output ready, y, s0, s1, s2, vld, frame
  );

endinterface

// File: rtl/tdm_bit_sel.sv
// Picks the word bit that belongs on the given channel.
module tdm_bit_sel
  import tdm_mux_8x1_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [NCH-1:0]  word_i,
  input  logic [CH_W-1:0] cnt_i,
  output logic            y_o
);

  assign y_o = word_i[chan_bit_idx(cnt_i, LSB_FIRST)];

endmodule

// File: rtl/tdm_mux_8x1.sv
// Time-division 8:1 multiplexer: serializes a handshaken parallel word onto
// y with channel select and frame marker, optionally followed by idle cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a word; ready=1, outputs quiet
// ST_SHIFT | sending channel cnt of the held word; vld=1
// ST_GAP   | post-frame idle; gap_q counts down to 0, then back to IDLE
module tdm_mux_8x1
  import tdm_mux_8x1_pkg::*;
#(
  parameter int unsigned GAP       = 0,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_mux_8x1_if.slave mux_io
);

  // Gap timer is a down-counter loaded with GAP-1 so that GAP cycles elapse
  // before the terminal count of zero releases the FSM.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP == 0) ? '0 : GAP_W'(GAP - 1);
  localparam bit               NO_GAP   = (GAP == 0);

  state_e           state_q, state_d;
  logic [CH_W-1:0]  cnt_q,   cnt_d;
  logic [NCH-1:0]   word_q,  word_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic             y_q,     y_d;
  logic [CH_W-1:0]  sel_q,   sel_d;
  logic             vld_q,   vld_d;
  logic             frame_q, frame_d;

  logic             ready;
  logic             accept;
  logic             bit_nxt;

  // Ready depends on state registers only, so load/d never reach it.
  assign ready  = (state_q == ST_IDLE) ||
                  ((state_q == ST_SHIFT) && (cnt_q == CNT_LAST) && NO_GAP);
  assign accept = mux_io.load && ready;

  // Next-state, channel counter, holding register and gap timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          word_d  = mux_io.d;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CH_W'(1);
        end else if (accept) begin
          cnt_d  = '0;
          word_d = mux_io.d;
        end else if (NO_GAP) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit selection works on the next word/channel so outputs can be registered
  // and still show channel 0 right after the accepting edge.
  tdm_bit_sel #(
    .LSB_FIRST (LSB_FIRST)
  ) u_bit_sel (
    .word_i (word_d),
    .cnt_i  (cnt_d),
    .y_o    (bit_nxt)
  );

  // Next values of the registered stream outputs; quiet outside SHIFT.
  always_comb begin
    vld_d   = (state_d == ST_SHIFT);
    sel_d   = '0;
    frame_d = 1'b0;
    y_d     = 1'b0;
    if (vld_d) begin
      sel_d   = cnt_d;
      frame_d = (cnt_d == '0);
      y_d     = bit_nxt;
    end
  end

  // State and output registers; reset aborts any frame in progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
      y_q     <= 1'b0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      frame_q <= frame_d;
    end
  end

  assign mux_io.ready = ready;
  assign mux_io.y     = y_q;
  assign mux_io.s0    = sel_q[0];
  assign mux_io.s1    = sel_q[1];
  assign mux_io.s2    = sel_q[2];
  assign mux_io.vld   = vld_q;
  assign mux_io.frame = frame_q;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
// Directed bench for tdm_mux_8x1: three configurations (GAP=0 LSB-first,
// GAP=0 MSB-first, GAP=3 LSB-first) driven from one vector table, plus a
// hand-written reset-mid-frame sequence.
module tb_tdm_mux_8x1;

  typedef struct {
    int unsigned dut;
    logic [7:0]  d;
    logic        load;
    logic [6:0]  exp;   // {ready, y, s2, s1, s0, vld, frame}
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  tdm_mux_8x1_if bus0();
  tdm_mux_8x1_if bus1();
  tdm_mux_8x1_if bus2();

  tdm_mux_8x1 #(.GAP(0), .LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .mux_io(bus0));
  tdm_mux_8x1 #(.GAP(0), .LSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .mux_io(bus1));
  tdm_mux_8x1 #(.GAP(3), .LSB_FIRST(1'b1)) dut2 (.clk(clk), .rst(rst), .mux_io(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] o(input bit r, input bit y, input int ch,
                                   input bit v, input bit f);
    return {r, y, 3'(ch), v, f};
  endfunction

  function automatic logic [6:0] rd(input int unsigned dut);
    case (dut)
      0:       return {bus0.ready, bus0.y, bus0.s2, bus0.s1, bus0.s0, bus0.vld, bus0.frame};
      1:       return {bus1.ready, bus1.y, bus1.s2, bus1.s1, bus1.s0, bus1.vld, bus1.frame};
      default: return {bus2.ready, bus2.y, bus2.s2, bus2.s1, bus2.s0, bus2.vld, bus2.frame};
    endcase
  endfunction

  task automatic apply(input int unsigned dut, input logic [7:0] d, input logic ld);
    bus0.load = 1'b0;
    bus1.load = 1'b0;
    bus2.load = 1'b0;
    case (dut)
      0:       begin bus0.d = d; bus0.load = ld; end
      1:       begin bus1.d = d; bus1.load = ld; end
      default: begin bus2.d = d; bus2.load = ld; end
    endcase
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got {rdy,y,sel,vld,frm}=%b required %b", name, got, exp);
    end
  endtask

  task automatic add(input int unsigned dut, input logic [7:0] d, input logic ld,
                     input logic [6:0] exp);
    vec_t v;
    v.dut  = dut;
    v.d    = d;
    v.load = ld;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // dut0: single word A6, LSB first -> y 0,1,1,0,0,1,0,1
    add(0, 8'hA6, 1'b1, o(0, 0, 0, 1, 1));
    add(0, 8'hA6, 1'b0, o(0, 1, 1, 1, 0));
    add(0, 8'hA6, 1'b0, o(0, 1, 2, 1, 0));
    add(0, 8'hA6, 1'b0, o(0, 0, 3, 1, 0));
    add(0, 8'hA6, 1'b0, o(0, 0, 4, 1, 0));
    add(0, 8'hA6, 1'b0, o(0, 1, 5, 1, 0));
    add(0, 8'hA6, 1'b0, o(0, 0, 6, 1, 0));
    add(0, 8'hA6, 1'b0, o(1, 1, 7, 1, 0));
    add(0, 8'hA6, 1'b0, o(1, 0, 0, 0, 0));
    // dut0: back-to-back FF then 00, sixteen consecutive vld cycles
    add(0, 8'hFF, 1'b1, o(0, 1, 0, 1, 1));
    for (int c = 1; c <= 6; c++) add(0, 8'hFF, 1'b1, o(0, 1, c, 1, 0));
    add(0, 8'hFF, 1'b1, o(1, 1, 7, 1, 0));
    add(0, 8'h00, 1'b1, o(0, 0, 0, 1, 1));
    for (int c = 1; c <= 6; c++) add(0, 8'h00, 1'b0, o(0, 0, c, 1, 0));
    add(0, 8'h00, 1'b0, o(1, 0, 7, 1, 0));
    add(0, 8'h00, 1'b0, o(1, 0, 0, 0, 0));
    // dut0: F0 frame with 55 loads visible during channels 2..5
    add(0, 8'hF0, 1'b1, o(0, 0, 0, 1, 1));
    add(0, 8'hF0, 1'b0, o(0, 0, 1, 1, 0));
    add(0, 8'h55, 1'b0, o(0, 0, 2, 1, 0));
    add(0, 8'h55, 1'b1, o(0, 0, 3, 1, 0));
    add(0, 8'h55, 1'b1, o(0, 1, 4, 1, 0));
    add(0, 8'h55, 1'b1, o(0, 1, 5, 1, 0));
    add(0, 8'h55, 1'b1, o(0, 1, 6, 1, 0));
    add(0, 8'h55, 1'b0, o(1, 1, 7, 1, 0));
    add(0, 8'h00, 1'b0, o(1, 0, 0, 0, 0));
    add(0, 8'h00, 1'b0, o(1, 0, 0, 0, 0));
    // dut1: C3, MSB first -> y 1,1,0,0,0,0,1,1
    add(1, 8'hC3, 1'b1, o(0, 1, 0, 1, 1));
    add(1, 8'hC3, 1'b0, o(0, 1, 1, 1, 0));
    add(1, 8'hC3, 1'b0, o(0, 0, 2, 1, 0));
    add(1, 8'hC3, 1'b0, o(0, 0, 3, 1, 0));
    add(1, 8'hC3, 1'b0, o(0, 0, 4, 1, 0));
    add(1, 8'hC3, 1'b0, o(0, 0, 5, 1, 0));
    add(1, 8'hC3, 1'b0, o(0, 1, 6, 1, 0));
    add(1, 8'hC3, 1'b0, o(1, 1, 7, 1, 0));
    add(1, 8'hC3, 1'b0, o(1, 0, 0, 0, 0));
    // dut2: GAP=3, load held high with 81 then 3C
    add(2, 8'h81, 1'b1, o(0, 1, 0, 1, 1));
    for (int c = 1; c <= 6; c++) add(2, 8'h3C, 1'b1, o(0, 0, c, 1, 0));
    add(2, 8'h3C, 1'b1, o(0, 1, 7, 1, 0));
    for (int g = 0; g < 3; g++) add(2, 8'h3C, 1'b1, o(0, 0, 0, 0, 0));
    add(2, 8'h3C, 1'b1, o(1, 0, 0, 0, 0));
    add(2, 8'h3C, 1'b1, o(0, 0, 0, 1, 1));
    add(2, 8'h3C, 1'b0, o(0, 0, 1, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 1, 2, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 1, 3, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 1, 4, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 1, 5, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 0, 6, 1, 0));
    add(2, 8'h3C, 1'b0, o(0, 0, 7, 1, 0));
    for (int g = 0; g < 3; g++) add(2, 8'h3C, 1'b0, o(0, 0, 0, 0, 0));
    add(2, 8'h3C, 1'b0, o(1, 0, 0, 0, 0));

    // Reset state
    rst = 1'b1;
    bus0.d = 8'h00; bus0.load = 1'b0;
    bus1.d = 8'h00; bus1.load = 1'b0;
    bus2.d = 8'h00; bus2.load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_dut0", rd(0), o(1, 0, 0, 0, 0));
    check("reset_dut1", rd(1), o(1, 0, 0, 0, 0));
    check("reset_dut2", rd(2), o(1, 0, 0, 0, 0));

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].dut, tbl[i].d, tbl[i].load);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_dut%0d", i, tbl[i].dut), rd(tbl[i].dut), tbl[i].exp);
    end

    // Reset mid-frame: abort AA at channel 4, restart cleanly with 01
    apply(0, 8'hAA, 1'b1);
    @(posedge clk);
    @(negedge clk);
    apply(0, 8'hAA, 1'b0);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_ch4", rd(0), o(0, 0, 4, 1, 0));
    rst = 1'b1;
    #1;
    check("midrst_async_drop", rd(0) & 7'b011_1111, 7'b000_0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_release", rd(0), o(1, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("midrst_quiet%0d", k), rd(0), o(1, 0, 0, 0, 0));
    end
    apply(0, 8'h01, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("midrst_restart_ch0", rd(0), o(0, 1, 0, 1, 1));
    apply(0, 8'h01, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_restart_ch1", rd(0), o(0, 0, 1, 1, 0));
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrst_done_idle", rd(0), o(1, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux_8x1.md
# tdm_mux_8x1

Time-division 8:1 multiplexer: accepts an 8-bit parallel word via a valid/ready handshake and serializes it onto a single line, one bit per clock. Alongside each bit it drives the 3-bit channel select {s2,s1,s0} and a frame marker, so the stream feeds our 1:8 demultiplexer directly. Sits at the transmit end of the select-addressed distribution path.

## Interface
- GAP, 0: idle cycles inserted after each frame before the next word is accepted; legal range 0..15.
- LSB_FIRST, 1: 1 sends d[0] on channel 0; 0 sends d[7] on channel 0.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- d  in  8  parallel word; sampled only on an accepted handshake.
- load  in  1  word valid.
- ready  out  1  block can accept a word this cycle.
- y  out  1  serial data bit for the current channel.
- s0, s1, s2  out  1 each  channel select; {s2,s1,s0} = channel index.
- vld  out  1  y and select are meaningful this cycle.
- frame  out  1  high on channel 0 of every frame.

## Operation
- Accept: load && ready at a rising edge captures d into an 8-bit holding register.
- States:
  - IDLE: ready=1, vld=0.
  - SHIFT: vld=1; 3-bit channel counter cnt runs 0..7.
  - GAP: ready=0, vld=0; gap counter runs 0..GAP-1.
- Transitions:
  - IDLE→SHIFT on accept, cnt=0.
  - SHIFT, cnt<7: cnt+1.
  - SHIFT, cnt==7:
    - with accept: cnt wraps to 0, new word loaded, stay SHIFT (back-to-back frames).
    - no accept and GAP==0: →IDLE.
    - no accept and GAP>0: →GAP.
  - GAP→IDLE after GAP cycles.
- ready = IDLE, or (SHIFT && cnt==7 && GAP==0). With GAP>0 ready is never high in SHIFT.
- Channel mapping:
  - In SHIFT: {s2,s1,s0}=cnt; y = word[cnt] (LSB_FIRST=1) or word[7-cnt] (LSB_FIRST=0); frame = (cnt==0).
  - Outside SHIFT: y=0, {s2,s1,s0}=000, frame=0.
- load while ready=0 is ignored. d is not re-sampled mid-frame, so a changing d has no effect on the current frame.
- cnt is exactly 3 bits; wrap 7→0 occurs only on a back-to-back accept.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, y=0, s2=s1=s0=0, vld=0, frame=0, ready=1 (once rst deasserts), holding register=0.
- All outputs except ready are registered. ready is decoded from state registers only; no combinational path from load or d.
- Latency: accept at edge k puts channel 0 on outputs after edge k. Channel n appears after edge k+n. Last bit is held until edge k+8.
- Throughput:
  - GAP=0: continuous 8 bits per 8 cycles, no bubbles.
  - Otherwise: one word per 8+GAP+1 cycles (the +1 is the IDLE accept cycle).
- Reset mid-frame: the frame is aborted immediately, with no partial completion after release. The first accept after release starts at channel 0.

## Structure
- Shared package (demux/mux family): channel-width constant CH_W=3, channel count NCH=8, state encoding constants IDLE/SHIFT/GAP.
- Single module. The bit select (word, cnt, LSB_FIRST → y) is a natural sub-module: tdm_bit_sel.

## Test plan
- Reset then single word, GAP=0, LSB_FIRST=1:
  - stimulus: d=8'b1010_0110 with one load pulse.
  - required: over 8 cycles y=0,1,1,0,0,1,0,1 with {s2,s1,s0}=000..111; frame high only at 000; then vld=0 and ready=1.
- LSB_FIRST=0:
  - stimulus: d=8'hC3.
  - required: y=1,1,0,0,0,0,1,1 on channels 0..7.
- Back-to-back, GAP=0:
  - stimulus: load held high with 8'hFF, then 8'h00 accepted at cnt==7.
  - required: sixteen consecutive vld cycles; select wraps 111→000; frame pulses at cycles 0 and 8; y switches 1→0 at the wrap.
- GAP=3:
  - stimulus: two words with load held high.
  - required: after channel 7, three cycles with ready=0 and vld=0, one IDLE accept cycle, then the second frame starts.
- Reset mid-frame:
  - stimulus: assert rst during channel 4 of 8'hAA.
  - required: y, select, vld and frame drop to 0 within the same cycle; after release ready=1 and the next word starts at channel 0.
- Ignored load:
  - stimulus: pulse load with 8'h55 during channels 2..5 of 8'hF0.
  - required: the F0 frame completes unaltered and 8'h55 is never transmitted.
